// File: rtl/time_base.sv
`default_nettype none
// ============================================================================
// Module      : time_base
// Description : Prescaled 64-bit machine time counter with a bus register port.
// Revision    : 1.0 - initial release
// ============================================================================
module time_base #(
    parameter int DIV_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        halt_in,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [63:0] cycle_out,
    output logic        tick_out
);

    localparam logic [1:0] C_REG_MTIME_LO = 2'd0;
    localparam logic [1:0] C_REG_MTIME_HI = 2'd1;
    localparam logic [1:0] C_REG_CTRL     = 2'd2;
    localparam logic [1:0] C_REG_STATUS   = 2'd3;
    localparam logic [DIV_WIDTH-1:0] C_PRE_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [63:0]          r_cycle;
    logic [31:0]          r_shadow;
    logic [DIV_WIDTH-1:0] r_prescale;
    logic [DIV_WIDTH-1:0] r_divisor;
    logic                 r_enable;
    logic                 r_overflow;
    logic                 r_tick;

    logic [1:0]  w_reg;
    logic        w_write;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_wr_ctrl;
    logic        w_clr_ovf;
    logic        w_snapshot;
    logic        w_active;
    logic        w_due;
    logic        w_inc;
    logic        w_ovf_set;
    logic [31:0] w_merged_lo;
    logic [31:0] w_merged_hi;
    logic [31:0] w_ctrl;
    logic [31:0] w_ctrl_merged;
    logic        w_unused;

    function automatic logic [31:0] f_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  mask
    );
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                v[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return v;
    endfunction

    assign w_reg      = address_in[3:2];
    assign w_write    = sel_in && (write_mask_in != 4'd0);
    assign w_wr_lo    = w_write && (w_reg == C_REG_MTIME_LO);
    assign w_wr_hi    = w_write && (w_reg == C_REG_MTIME_HI);
    assign w_wr_ctrl  = w_write && (w_reg == C_REG_CTRL);
    assign w_clr_ovf  = w_write && (w_reg == C_REG_STATUS) && write_mask_in[0] && write_value_in[0];
    // A write cycle never snapshots, even with read_in asserted.
    assign w_snapshot = sel_in && read_in && !w_write && (w_reg == C_REG_MTIME_LO);

    assign w_active  = r_enable && !halt_in;
    assign w_due     = w_active && (r_prescale == r_divisor);
    assign w_inc     = w_due && !w_wr_lo && !w_wr_hi;
    assign w_ovf_set = w_inc && (r_cycle == {64{1'b1}});

    assign w_merged_lo   = f_merge(r_cycle[31:0], write_value_in, write_mask_in);
    assign w_merged_hi   = f_merge(r_cycle[63:32], write_value_in, write_mask_in);
    assign w_ctrl_merged = f_merge(w_ctrl, write_value_in, write_mask_in);

    always_comb begin
        w_ctrl                  = 32'd0;
        w_ctrl[0]               = r_enable;
        w_ctrl[8 +: DIV_WIDTH]  = r_divisor;
    end

    always_comb begin
        read_value_out = 32'd0;
        if (sel_in) begin
            case (w_reg)
                C_REG_MTIME_LO: read_value_out = r_cycle[31:0];
                C_REG_MTIME_HI: read_value_out = r_shadow;
                C_REG_CTRL:     read_value_out = w_ctrl;
                default:        read_value_out = {31'd0, r_overflow};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle    <= 64'd0;
            r_shadow   <= 32'd0;
            r_prescale <= '0;
            r_divisor  <= '0;
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= w_inc;

            // MTIME writes override a due increment on the same edge.
            if (w_wr_lo) begin
                r_cycle <= {r_cycle[63:32], w_merged_lo};
            end else if (w_wr_hi) begin
                r_cycle <= {w_merged_hi, r_cycle[31:0]};
            end else if (w_inc) begin
                r_cycle <= r_cycle + 64'd1;
            end

            if (w_wr_lo || w_wr_hi || w_wr_ctrl || w_due) begin
                r_prescale <= '0;
            end else if (w_active) begin
                r_prescale <= r_prescale + C_PRE_ONE;
            end

            if (w_wr_hi) begin
                r_shadow <= w_merged_hi;
            end else if (w_snapshot) begin
                r_shadow <= r_cycle[63:32];
            end

            if (w_wr_ctrl) begin
                r_enable  <= w_ctrl_merged[0];
                r_divisor <= w_ctrl_merged[8 +: DIV_WIDTH];
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign cycle_out = r_cycle;
    assign tick_out  = r_tick;

    assign w_unused = ^{address_in[31:4], address_in[1:0], w_ctrl_merged};

endmodule
`default_nettype wire

// File: tb/tb_time_base.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_base
// Description : Self-checking bench for time_base against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_base;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        halt_in = 1'b0;
    logic [31:0] address_in = 32'd0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = 4'd0;
    logic [31:0] write_value_in = 32'd0;
    logic [63:0] cycle_out;
    logic        tick_out;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    time_base #(.DIV_WIDTH(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .halt_in        (halt_in),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .cycle_out      (cycle_out),
        .tick_out       (tick_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] cycle;
        logic [31:0] shadow;
        logic [7:0]  pre;
        logic [7:0]  div;
        logic        en;
        logic        ovf;
        logic        tick;
    } model_t;

    model_t m;

    function automatic model_t reset_model();
        model_t r;
        r = '0;
        r.en = 1'b1;
        return r;
    endfunction

    // One clock edge of the time base, written from the register-level rules.
    function automatic model_t step(input model_t s, input logic halt, input logic sel,
                                    input logic rd, input logic [1:0] a,
                                    input logic [3:0] mk, input logic [31:0] d);
        model_t n;
        logic wr;
        logic [31:0] half;
        logic [31:0] ctrl;
        n = s;
        wr = sel && (mk != 4'd0);
        n.tick = 1'b0;
        if (sel && rd && !wr && a == 2'd0) n.shadow = s.cycle[63:32];
        if (wr && a == 2'd3 && mk[0] && d[0]) n.ovf = 1'b0;
        if (wr && a <= 2'd1) begin
            half = (a == 2'd0) ? s.cycle[31:0] : s.cycle[63:32];
            for (int b = 0; b < 4; b++) if (mk[b]) half[8*b +: 8] = d[8*b +: 8];
            if (a == 2'd0) n.cycle[31:0] = half;
            else begin
                n.cycle[63:32] = half;
                n.shadow = half;
            end
            n.pre = 8'd0;
        end else if (s.en && !halt) begin
            if (s.pre == s.div) begin
                n.pre = 8'd0;
                n.cycle = s.cycle + 64'd1;
                n.tick = 1'b1;
                if (s.cycle == {64{1'b1}}) n.ovf = 1'b1;
            end else begin
                n.pre = s.pre + 8'd1;
            end
        end
        if (wr && a == 2'd2) begin
            ctrl = {16'd0, s.div, 7'd0, s.en};
            for (int b = 0; b < 4; b++) if (mk[b]) ctrl[8*b +: 8] = d[8*b +: 8];
            n.en = ctrl[0];
            n.div = ctrl[15:8];
            n.pre = 8'd0;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_read(input model_t s, input logic sel, input logic [1:0] a);
        if (!sel) return 32'd0;
        case (a)
            2'd0:    return s.cycle[31:0];
            2'd1:    return s.shadow;
            2'd2:    return {16'd0, s.div, 7'd0, s.en};
            default: return {31'd0, s.ovf};
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= reset_model();
        else m <= step(m, halt_in, sel_in, read_in, address_in[3:2], write_mask_in, write_value_in);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("model_cycle", cycle_out, m.cycle);
            check("model_tick", 64'(tick_out), 64'(m.tick));
            check("model_rdata", 64'(read_value_out),
                  64'(exp_read(m, sel_in, address_in[3:2])));
        end
    end

    task automatic idle();
        sel_in = 1'b0;
        read_in = 1'b0;
        write_mask_in = 4'd0;
        write_value_in = 32'd0;
        address_in = 32'd0;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] mk, input logic [31:0] d);
        sel_in = 1'b1;
        read_in = 1'b0;
        address_in = a;
        write_mask_in = mk;
        write_value_in = d;
        edge1();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        sel_in = 1'b1;
        read_in = 1'b1;
        address_in = a;
        write_mask_in = 4'd0;
        #2;
        v = read_value_out;
        edge1();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] c;
        logic [31:0] v;
        int ticks;

        edge1();
        mon_en = 1'b1;
        check("reset_cycle", cycle_out, 64'd0);
        check("reset_tick", 64'(tick_out), 64'd0);
        edge1();
        reset_n = 1'b1;

        // Divisor 0: one increment per edge.
        repeat (10) edge1();
        check("div0_cycle10", cycle_out, 64'd10);
        check("div0_tick", 64'(tick_out), 64'd1);

        // Divisor 3: the write edge still counts under the old divisor.
        wr(32'h8, 4'hF, 32'h0000_0301);
        check("ctrl_write_edge", cycle_out, 64'd11);
        c = cycle_out;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            edge1();
            if (tick_out) ticks++;
        end
        check("div3_delta", cycle_out - c, 64'd3);
        check("div3_ticks", 64'(ticks), 64'd3);
        rd(32'h8, v);
        check("ctrl_read", 64'(v), 64'h301);

        // Masked byte write to MTIME_LO while counting.
        wr(32'h8, 4'hF, 32'h1);
        repeat (3) edge1();
        c = cycle_out;
        wr(32'h0, 4'b0010, 32'h0000_AB00);
        check("mask_write", cycle_out, {c[63:16], 8'hAB, c[7:0]});
        check("mask_no_tick", 64'(tick_out), 64'd0);
        edge1();
        check("mask_resume", cycle_out, {c[63:16], 8'hAB, c[7:0]} + 64'd1);

        // Shadowed high word read across a carry.
        wr(32'h4, 4'hF, 32'h0);
        wr(32'h0, 4'hF, 32'hFFFF_FFFF);
        check("carry_setup", cycle_out, 64'h0000_0000_FFFF_FFFF);
        rd(32'h0, v);
        check("snap_lo", 64'(v), 64'hFFFF_FFFF);
        edge1();
        rd(32'h4, v);
        check("snap_hi_shadow", 64'(v), 64'h0);
        check("snap_live_hi", cycle_out, 64'h0000_0001_0000_0002);

        // Wrap from all-ones and sticky overflow.
        wr(32'h0, 4'hF, 32'hFFFF_FFFF);
        wr(32'h4, 4'hF, 32'hFFFF_FFFF);
        check("wrap_setup", cycle_out, {64{1'b1}});
        edge1();
        check("wrap_zero", cycle_out, 64'd0);
        rd(32'hC, v);
        check("ovf_set", 64'(v), 64'd1);
        wr(32'hC, 4'h1, 32'h1);
        rd(32'hC, v);
        check("ovf_clear", 64'(v), 64'd0);
        wr(32'h0, 4'hF, 32'hFFFF_FFFF);
        wr(32'h4, 4'hF, 32'hFFFF_FFFF);
        wr(32'hC, 4'h1, 32'h1);
        rd(32'hC, v);
        check("ovf_set_wins", 64'(v), 64'd1);
        wr(32'hC, 4'h1, 32'h1);

        // Disabled counter holds.
        wr(32'h8, 4'hF, 32'h0);
        c = cycle_out;
        repeat (4) edge1();
        check("disable_hold", cycle_out, c);

        // Halt mid-count, write under halt, then asynchronous reset.
        wr(32'h8, 4'hF, 32'h0000_0201);
        repeat (5) edge1();
        halt_in = 1'b1;
        c = cycle_out;
        repeat (5) edge1();
        check("halt_freeze", cycle_out, c);
        wr(32'h0, 4'b0001, 32'h0000_005A);
        check("halt_write", cycle_out, {c[63:8], 8'h5A});
        #2;
        reset_n = 1'b0;
        sel_in = 1'b1;
        address_in = 32'h8;
        #1;
        check("async_cycle", cycle_out, 64'd0);
        check("async_tick", 64'(tick_out), 64'd0);
        check("async_ctrl", 64'(read_value_out), 64'h1);
        address_in = 32'h4;
        #1;
        check("async_shadow", 64'(read_value_out), 64'h0);
        halt_in = 1'b0;
        idle();
        edge1();
        reset_n = 1'b1;
        repeat (5) edge1();
        check("post_reset_count", cycle_out, 64'd5);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
